dcache_ctrl: RTL and testbench



---
 rtl/dcache_pkg.sv | 62 ++++++
 rtl/dcache_ctrl_if.sv | 23 ++
 rtl/dcache_vd_bits.sv | 37 +++
 rtl/dcache_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared widths, FSM state type and address/line helpers for the data-cache controller.
package dcache_pkg;
  localparam int IDX_W    = 5;
  localparam int TAG_W    = 7;
  localparam int LINE_W   = 128;
  localparam int ADDR_W   = 16;
  localparam int NLINES   = 1 << IDX_W;
  localparam int OCM_AW   = IDX_W + TAG_W;
  localparam int BYTES_LN = LINE_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_RF_REQ,
    ST_RF_WAIT,
    ST_RF_FILL
  } state_e;

  typedef struct packed {
    logic [LINE_W-1:0]   line;
    logic [BYTES_LN-1:0] mask;
  } merge_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[15:9];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[8:4];
  endfunction

  function automatic logic [1:0] word_of(input logic [ADDR_W-1:0] a);
    return a[3:2];
  endfunction

  function automatic logic [31:0] word_pick(input logic [LINE_W-1:0] line, input logic [1:0] w);
    logic [31:0] r;
    case (w)
      2'd0:    r = line[31:0];
      2'd1:    r = line[63:32];
      2'd2:    r = line[95:64];
      default: r = line[127:96];
    endcase
    return r;
  endfunction

  // Byte mask comes back alongside the line so a hit can drive the per-byte WENs directly.
  function automatic merge_t word_merge(input logic [LINE_W-1:0] line, input logic [1:0] word_sel,
                                        input logic [31:0] wdata, input logic [3:0] wstrb);
    merge_t m;
    m.line = line;
    m.mask = '0;
    for (int i = 0; i < BYTES_LN; i++) begin
      if ((i / 4) == int'(word_sel) && wstrb[i % 4]) begin
        m.line[i*8 +: 8] = wdata[(i % 4)*8 +: 8];
        m.mask[i]        = 1'b1;
      end
    end
    return m;
  endfunction
endpackage

// File: rtl/dcache_ctrl_if.sv
// LSU request/response channel between the load-store unit (master) and the cache (slave).
interface dcache_ctrl_if;
  import dcache_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dcache_vd_bits.sv
// Per-line valid and dirty flags; cleared asynchronously so a reset invalidates the whole cache.
module dcache_vd_bits
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              valid_set_i,
  input  logic              dirty_set_i,
  input  logic              dirty_clr_i,
  output logic [NLINES-1:0] valid_o,
  output logic [NLINES-1:0] dirty_o
);
  logic [NLINES-1:0] valid_q, valid_d;
  logic [NLINES-1:0] dirty_q, dirty_d;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (valid_set_i) valid_d[idx_i] = 1'b1;
    if (dirty_set_i)      dirty_d[idx_i] = 1'b1;
    else if (dirty_clr_i) dirty_d[idx_i] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  assign valid_o = valid_q;
  assign dirty_o = dirty_q;
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate controller: tag/data macro sequencing, victim write-back and OCM refill.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  dcache_ctrl_if.slave        lsu,
  output logic                tag_cena_o,
  output logic [IDX_W-1:0]    tag_aa_o,
  input  logic [TAG_W-1:0]    tag_qa_i,
  output logic                tag_cenb_o,
  output logic [IDX_W-1:0]    tag_ab_o,
  output logic [TAG_W-1:0]    tag_db_o,
  output logic                mem_cen_o,
  output logic [BYTES_LN-1:0] mem_wen_o,
  output logic [IDX_W-1:0]    mem_a_o,
  output logic [LINE_W-1:0]   mem_d_o,
  input  logic [LINE_W-1:0]   mem_q_i,
  output logic                ocm_req_o,
  input  logic                ocm_gnt_i,
  output logic                ocm_wen_o,
  output logic [OCM_AW-1:0]   ocm_a_o,
  output logic [LINE_W-1:0]   ocm_d_o,
  input  logic [LINE_W-1:0]   ocm_q_i
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [LINE_W-1:0] victim_q, victim_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic [NLINES-1:0] vd_valid, vd_dirty;
  logic              vd_valid_set, vd_dirty_set, vd_dirty_clr;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        req_word;
  logic              hit;
  merge_t            st_m, fill_m;
  logic [LINE_W-1:0] fill_line;

  assign req_tag  = tag_of(addr_q);
  assign req_idx  = idx_of(addr_q);
  assign req_word = word_of(addr_q);
  assign hit      = vd_valid[req_idx] && (tag_qa_i == req_tag);

  dcache_vd_bits u_vd (
    .clk         (clk),
    .rst         (rst),
    .idx_i       (req_idx),
    .valid_set_i (vd_valid_set),
    .dirty_set_i (vd_dirty_set),
    .dirty_clr_i (vd_dirty_clr),
    .valid_o     (vd_valid),
    .dirty_o     (vd_dirty)
  );

  assign lsu.req_ready = (state_q == ST_IDLE);
  assign lsu.rsp_valid = rsp_valid_q;
  assign lsu.rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    victim_d     = victim_q;
    vtag_d       = vtag_q;
    line_d       = line_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    vd_valid_set = 1'b0;
    vd_dirty_set = 1'b0;
    vd_dirty_clr = 1'b0;
    tag_cena_o   = 1'b1;
    tag_aa_o     = '0;
    tag_cenb_o   = 1'b1;
    tag_ab_o     = '0;
    tag_db_o     = '0;
    mem_cen_o    = 1'b1;
    mem_wen_o    = '1;
    mem_a_o      = '0;
    mem_d_o      = '0;
    ocm_req_o    = 1'b0;
    ocm_wen_o    = 1'b1;
    ocm_a_o      = '0;
    ocm_d_o      = '0;
    st_m         = word_merge(mem_q_i, req_word, wdata_q, wstrb_q);
    fill_m       = word_merge(line_q, req_word, wdata_q, wstrb_q);
    fill_line    = we_q ? fill_m.line : line_q;

    case (state_q)
      ST_IDLE: begin
        if (lsu.req_valid) begin
          addr_d     = lsu.req_addr;
          we_d       = lsu.req_we;
          wdata_d    = lsu.req_wdata;
          wstrb_d    = lsu.req_wstrb;
          tag_cena_o = 1'b0;
          tag_aa_o   = idx_of(lsu.req_addr);
          mem_cen_o  = 1'b0;
          mem_a_o    = idx_of(lsu.req_addr);
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
          if (we_q) begin
            mem_cen_o    = 1'b0;
            mem_wen_o    = ~st_m.mask;
            mem_a_o      = req_idx;
            mem_d_o      = st_m.line;
            vd_dirty_set = 1'b1;
          end else begin
            rsp_rdata_d = word_pick(mem_q_i, req_word);
          end
        end else if (vd_valid[req_idx] && vd_dirty[req_idx]) begin
          victim_d = mem_q_i;
          vtag_d   = tag_qa_i;
          state_d  = ST_WB;
        end else begin
          state_d = ST_RF_REQ;
        end
      end
      ST_WB: begin
        ocm_req_o = 1'b1;
        ocm_wen_o = 1'b0;
        ocm_a_o   = {vtag_q, req_idx};
        ocm_d_o   = victim_q;
        if (ocm_gnt_i) begin
          vd_dirty_clr = 1'b1;
          state_d      = ST_RF_REQ;
        end
      end
      ST_RF_REQ: begin
        ocm_req_o = 1'b1;
        ocm_a_o   = {req_tag, req_idx};
        if (ocm_gnt_i) state_d = ST_RF_WAIT;
      end
      ST_RF_WAIT: begin
        line_d  = ocm_q_i;
        state_d = ST_RF_FILL;
      end
      ST_RF_FILL: begin
        mem_cen_o    = 1'b0;
        mem_wen_o    = '0;
        mem_a_o      = req_idx;
        mem_d_o      = fill_line;
        tag_cenb_o   = 1'b0;
        tag_ab_o     = req_idx;
        tag_db_o     = req_tag;
        vd_valid_set = 1'b1;
        vd_dirty_set = we_q;
        vd_dirty_clr = !we_q;
        rsp_valid_d  = 1'b1;
        rsp_rdata_d  = we_q ? 32'd0 : word_pick(fill_line, req_word);
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      victim_q    <= '0;
      vtag_q      <= '0;
      line_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      victim_q    <= victim_d;
      vtag_q      <= vtag_d;
      line_q      <= line_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural tag/data/OCM macros, reference cache model and response/OCM scoreboards.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_ctrl_if lsu_if ();

  logic         tag_cena, tag_cenb, mem_cen, ocm_req, ocm_wen;
  logic [4:0]   tag_aa, tag_ab, mem_a;
  logic [6:0]   tag_qa = '0;
  logic [6:0]   tag_db;
  logic [15:0]  mem_wen;
  logic [127:0] mem_d, ocm_d;
  logic [127:0] mem_q = '0;
  logic [127:0] ocm_q = '0;
  logic [11:0]  ocm_a;
  logic         ocm_gnt = 1'b0;

  dcache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .lsu        (lsu_if.slave),
    .tag_cena_o (tag_cena),
    .tag_aa_o   (tag_aa),
    .tag_qa_i   (tag_qa),
    .tag_cenb_o (tag_cenb),
    .tag_ab_o   (tag_ab),
    .tag_db_o   (tag_db),
    .mem_cen_o  (mem_cen),
    .mem_wen_o  (mem_wen),
    .mem_a_o    (mem_a),
    .mem_d_o    (mem_d),
    .mem_q_i    (mem_q),
    .ocm_req_o  (ocm_req),
    .ocm_gnt_i  (ocm_gnt),
    .ocm_wen_o  (ocm_wen),
    .ocm_a_o    (ocm_a),
    .ocm_d_o    (ocm_d),
    .ocm_q_i    (ocm_q)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [11:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = {8'hC0, 4'h0, a, 4'h0, 4'(k)};
    return l;
  endfunction

  // Macro models
  logic [6:0]   tag_ram [32];
  logic [127:0] mem_ram [32];
  logic [127:0] ocm_ram [4096];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!tag_cena) tag_qa <= tag_ram[tag_aa];
    if (!tag_cenb) tag_ram[tag_ab] <= tag_db;
    if (!mem_cen) begin
      mem_q <= mem_ram[mem_a];
      for (int b = 0; b < 16; b++)
        if (!mem_wen[b]) mem_ram[mem_a][b*8 +: 8] <= mem_d[b*8 +: 8];
    end
    if (ocm_req && ocm_gnt) begin
      if (!ocm_wen) ocm_ram[ocm_a] <= ocm_d;
      else          ocm_q <= ocm_ram[ocm_a];
    end
  end

  // Reference cache model
  logic [127:0] ref_ocm  [4096];
  logic [127:0] ref_line [32];
  logic [6:0]   ref_tag  [32];
  logic [31:0]  ref_valid = '0;
  logic [31:0]  ref_dirty = '0;

  typedef struct { logic [31:0] rdata; int issue; int lat; } rsp_exp_t;
  typedef struct { logic wen; logic [11:0] a; logic [127:0] d; } ocm_exp_t;
  rsp_exp_t rsp_exp[$];
  ocm_exp_t ocm_exp[$];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ocm_ram[i] = init_line(12'(i));
      ref_ocm[i] = init_line(12'(i));
    end
    for (int i = 0; i < 32; i++) begin
      tag_ram[i]  = '0;
      mem_ram[i]  = '0;
      ref_line[i] = '0;
      ref_tag[i]  = '0;
    end
  end

  // Response scoreboard
  always @(negedge clk) begin
    if (!rst && lsu_if.rsp_valid) begin
      if (rsp_exp.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        rsp_exp_t e;
        e = rsp_exp.pop_front();
        chk("rsp_rdata", lsu_if.rsp_rdata, e.rdata);
        if (e.lat >= 0) chk("hit_latency", cyc - e.issue, e.lat);
      end
    end
  end

  // OCM arbiter: grants after gnt_delay waiting cycles, checks hold stability and expected accesses
  int           gnt_delay = 0;
  int           gnt_wait  = 0;
  int           hold_n    = 0;
  int           ocm_req_cyc = 0;
  bit           have_snap = 0;
  logic         snap_wen;
  logic [11:0]  snap_a;
  logic [127:0] snap_d;
  logic [15:0]  last_wen = '1;

  always @(negedge clk) begin
    if (!mem_cen && mem_wen != 16'hFFFF) last_wen = mem_wen;
    if (rst) begin
      ocm_gnt   = 1'b0;
      gnt_wait  = 0;
      have_snap = 0;
    end else if (ocm_gnt) begin
      ocm_gnt   = 1'b0;
      have_snap = 0;
    end else if (ocm_req) begin
      ocm_req_cyc++;
      if (have_snap) begin
        hold_n++;
        chk("hold_wen", ocm_wen, snap_wen);
        chk("hold_a", ocm_a, snap_a);
        chk("hold_d", ocm_d, snap_d);
      end else begin
        have_snap = 1;
        snap_wen  = ocm_wen;
        snap_a    = ocm_a;
        snap_d    = ocm_d;
      end
      if (gnt_wait >= gnt_delay) begin
        if (ocm_exp.size() == 0) begin
          chk("ocm_unexpected", 1, 0);
        end else begin
          ocm_exp_t o;
          o = ocm_exp.pop_front();
          chk("ocm_wen", ocm_wen, o.wen);
          chk("ocm_a", ocm_a, o.a);
          if (!o.wen) chk("ocm_wb_data", ocm_d, o.d);
        end
        ocm_gnt  = 1'b1;
        gnt_wait = 0;
      end else begin
        gnt_wait++;
      end
    end
  end

  task automatic issue(input logic [15:0] addr, input logic we, input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [6:0]   t;
    logic [4:0]   ix;
    logic [1:0]   w;
    logic [127:0] ln;
    bit           hit;
    rsp_exp_t     e;
    ocm_exp_t     o;
    int           n;
    t  = addr[15:9];
    ix = addr[8:4];
    w  = addr[3:2];
    n  = 0;
    while (!lsu_if.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!lsu_if.req_ready) chk("ready_timeout", 0, 1);
    hit = ref_valid[ix] && (ref_tag[ix] == t);
    if (!hit) begin
      if (ref_valid[ix] && ref_dirty[ix]) begin
        o.wen = 1'b0; o.a = {ref_tag[ix], ix}; o.d = ref_line[ix];
        ocm_exp.push_back(o);
        ref_ocm[o.a] = ref_line[ix];
      end
      o.wen = 1'b1; o.a = {t, ix}; o.d = '0;
      ocm_exp.push_back(o);
      ref_line[ix]  = ref_ocm[{t, ix}];
      ref_valid[ix] = 1'b1;
      ref_tag[ix]   = t;
      ref_dirty[ix] = 1'b0;
    end
    if (we) begin
      ln = ref_line[ix];
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ln[w*32 + b*8 +: 8] = wdata[b*8 +: 8];
      ref_line[ix]  = ln;
      ref_dirty[ix] = 1'b1;
      e.rdata = '0;
    end else begin
      e.rdata = ref_line[ix][w*32 +: 32];
    end
    e.issue = cyc;
    e.lat   = hit ? 2 : -1;
    rsp_exp.push_back(e);
    lsu_if.req_valid = 1'b1;
    lsu_if.req_addr  = addr;
    lsu_if.req_we    = we;
    lsu_if.req_wdata = wdata;
    lsu_if.req_wstrb = wstrb;
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
  endtask

  task automatic run(input logic [15:0] addr, input logic we, input logic [31:0] wdata, input logic [3:0] wstrb);
    int n;
    issue(addr, we, wdata, wstrb);
    n = 0;
    while (rsp_exp.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rsp_exp.size() != 0) begin
      chk("rsp_timeout", rsp_exp.size(), 0);
      rsp_exp.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n0;
    int n;
    logic [6:0] t;
    logic [4:0] ix;
    logic [1:0] w;

    lsu_if.req_valid = 1'b0;
    lsu_if.req_addr  = '0;
    lsu_if.req_we    = 1'b0;
    lsu_if.req_wdata = '0;
    lsu_if.req_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", lsu_if.req_ready, 1);
    chk("rst_rsp_valid", lsu_if.rsp_valid, 0);
    chk("rst_rsp_rdata", lsu_if.rsp_rdata, 0);
    chk("rst_tag_cen", {tag_cena, tag_cenb}, 2'b11);
    chk("rst_mem_cen", mem_cen, 1);
    chk("rst_mem_wen", mem_wen, 16'hFFFF);
    chk("rst_ocm_req", ocm_req, 0);
    chk("rst_ocm_wen", ocm_wen, 1);
    chk("rst_ocm_a", ocm_a, 0);
    rst = 1'b0;
    @(negedge clk);

    run(16'h0010, 1'b0, '0, '0);
    chk("fill_valid1", dut.vd_valid[1], 1);
    chk("fill_dirty1", dut.vd_dirty[1], 0);

    n0 = ocm_req_cyc;
    run(16'h0014, 1'b0, '0, '0);
    chk("hit_no_ocm", ocm_req_cyc - n0, 0);

    last_wen = '1;
    run(16'h0018, 1'b1, 32'hDEADBEEF, 4'b0011);
    chk("st_hit_wen", last_wen, 16'hFCFF);
    chk("st_hit_dirty1", dut.vd_dirty[1], 1);
    run(16'h0018, 1'b0, '0, '0);

    gnt_delay = 5;
    hold_n    = 0;
    run(16'h0210, 1'b0, '0, '0);
    chk("hold_cycles", hold_n, 10);
    chk("wb_dirty1", dut.vd_dirty[1], 0);
    chk("wb_ocm_line", ocm_ram[12'h001][95:64], 32'hC000BEEF);
    gnt_delay = 0;

    last_wen = '1;
    run(16'h0424, 1'b1, 32'h12345678, 4'b1111);
    chk("st_miss_wen", last_wen, 16'h0000);
    chk("st_miss_dirty2", dut.vd_dirty[2], 1);
    run(16'h0424, 1'b0, '0, '0);
    last_wen = '1;
    run(16'h0420, 1'b1, 32'hFFFFFFFF, 4'b0000);
    chk("st_zero_wen", last_wen, 16'hFFFF);
    run(16'h0420, 1'b0, '0, '0);

    // Abort a refill while its OCM read data is in flight
    gnt_delay = 2;
    issue(16'h0810, 1'b0, '0, '0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(ocm_gnt && ocm_wen) && n < 100);
    if (!(ocm_gnt && ocm_wen)) chk("rf_grant_timeout", 0, 1);
    chk("pre_rst_state", dut.state_q, ST_RF_WAIT);
    rst = 1'b1;
    #1;
    chk("abort_state", dut.state_q, ST_IDLE);
    chk("abort_valid", dut.vd_valid, 32'h0);
    chk("abort_ocm_req", ocm_req, 0);
    chk("abort_ready", lsu_if.req_ready, 1);
    rsp_exp.delete();
    ref_valid = '0;
    ref_dirty = '0;
    @(negedge clk);
    rst = 1'b0;
    gnt_delay = 0;
    chk("abort_ocm_left", ocm_exp.size(), 0);
    n0 = ocm_req_cyc;
    run(16'h0010, 1'b0, '0, '0);
    chk("post_rst_miss", ocm_req_cyc - n0 > 0, 1);

    for (int i = 0; i < 24; i++) begin
      t  = 7'($urandom_range(0, 3));
      ix = 5'($urandom_range(0, 3));
      w  = 2'($urandom_range(0, 3));
      gnt_delay = $urandom_range(0, 3);
      run({t, ix, w, 2'b00}, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end

    chk("ocm_left", ocm_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
